// File: rtl/dec2x4_hold_pkg.sv
// Shared types and helpers for the registered 2-to-4 decoder.
// Also used by the encoder round-trip checks.
package dec_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam logic [3:0] ONEHOT_NONE = 4'b0000;

   function automatic logic [3:0] onehot2(input logic [1:0] c);
      onehot2 = 4'b0001 << c;
   endfunction

endpackage

// File: rtl/dec2x4_hold_comb.sv
// Pure combinational 2-to-4 decoder with enable.
// The output is all-zero when disabled.
module dec2x4_comb
   import dec_pkg::*;
(
   input  logic       en_i,
   input  logic [1:0] code_i,
   output logic [3:0] y_o
);

   always_comb begin
      y_o = en_i ? onehot2(code_i) : ONEHOT_NONE;
   end

endmodule

// File: rtl/dec2x4_hold.sv
// Registered 2-to-4 decoder: accepts codes over valid/ready, holds each one-hot for HOLD_CYCLES
// cycles, and buffers one pending code so back-to-back codes show with no idle gap.
module dec2x4_hold
   import dec_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] code,
   output logic [3:0] y,
   output logic       y_valid,
   output logic       busy
);

   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        code_q, code_d;
   logic              pend_full_q, pend_full_d;
   logic [1:0]        pend_code_q, pend_code_d;

   logic xfer, slot_free, take_pend, take_in, hold_act;

   assign in_ready  = !pend_full_q;
   assign xfer      = in_valid & in_ready;
   // Output slot is free when idle or when the current code shows its last cycle.
   assign slot_free = (state_q == IDLE) | (cnt_q == '0);
   assign take_pend = en & slot_free & pend_full_q;
   assign take_in   = en & slot_free & !pend_full_q & xfer;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      code_d      = code_q;
      pend_full_d = pend_full_q;
      pend_code_d = pend_code_q;

      if (en && (state_q == HOLD) && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntOne;
      end

      if (take_pend) begin
         state_d     = HOLD;
         code_d      = pend_code_q;
         cnt_d       = CntLoad;
         pend_full_d = 1'b0;
      end else if (take_in) begin
         state_d = HOLD;
         code_d  = code;
         cnt_d   = CntLoad;
      end else if (en && slot_free) begin
         state_d = IDLE;
      end

      // A transfer not consumed directly lands in the pending slot (in_ready guarantees room).
      if (xfer && !take_in) begin
         pend_full_d = 1'b1;
         pend_code_d = code;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         code_q      <= 2'b00;
         pend_full_q <= 1'b0;
         pend_code_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         code_q      <= code_d;
         pend_full_q <= pend_full_d;
         pend_code_q <= pend_code_d;
      end
   end

   assign hold_act = en & (state_q == HOLD);
   assign y_valid  = hold_act;
   assign busy     = (state_q == HOLD) | pend_full_q;

   dec2x4_comb u_dec (
      .en_i   (hold_act),
      .code_i (code_q),
      .y_o    (y)
   );

endmodule

// File: tb/tb_dec2x4_hold.sv
// Bench for dec2x4_hold: per-cycle vector table on a HOLD_CYCLES=4 instance, and a
// priority-encoder round trip on a HOLD_CYCLES=1 instance checked through a scoreboard.
module tb_dec2x4_hold;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic       vld;
      logic [1:0] code;
      logic [3:0] ey;
      logic       ev;
      logic       er;
      logic       eb;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n, en, in_valid;
   logic [1:0] code;
   logic       in_ready, y_valid, busy;
   logic [3:0] y;

   logic       rt_valid;
   logic [1:0] rt_code;
   logic       rt_ready, rt_y_valid, rt_busy;
   logic [3:0] rt_y;

   int checks = 0;
   int errors = 0;
   int rt_seen = 0;
   bit rt_on = 1'b0;
   vec_t tbl[$];
   logic [3:0] sb[$];

   always #5 clk = ~clk;

   dec2x4_hold #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .code     (code),
      .y        (y),
      .y_valid  (y_valid),
      .busy     (busy)
   );

   dec2x4_hold #(.HOLD_CYCLES(1), .CNT_W(8)) u_rt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (1'b1),
      .in_valid (rt_valid),
      .in_ready (rt_ready),
      .code     (rt_code),
      .y        (rt_y),
      .y_valid  (rt_y_valid),
      .busy     (rt_busy)
   );

   task automatic add(input logic r, input logic e, input logic v, input logic [1:0] c,
                      input logic [3:0] ey, input logic ev, input logic er, input logic eb);
      vec_t t;
      t.rst_n = r; t.en = e; t.vld = v; t.code = c;
      t.ey = ey; t.ev = ev; t.er = er; t.eb = eb;
      tbl.push_back(t);
   endtask

   // Independent model of the upstream 4-to-2 priority encoder.
   function automatic logic [1:0] prio(input int r);
      if (r[3]) return 2'd3;
      if (r[2]) return 2'd2;
      if (r[1]) return 2'd1;
      return 2'd0;
   endfunction

   // Scoreboard: every visible round-trip output must match the oldest accepted code.
   always @(negedge clk) begin
      if (rt_on && rt_y_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rt_extra: got y=%b with no code outstanding", rt_y);
         end else begin
            logic [3:0] exp_y;
            exp_y = sb.pop_front();
            rt_seen++;
            if (rt_y !== exp_y) begin
               errors++;
               $display("FAIL rt_y: got %b want %b", rt_y, exp_y);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; code = 2'b00;
      rt_valid = 1'b0; rt_code = 2'b00;

      // reset, then single code 2'b10
      add(0,1,0,0, 4'b0000,0,1,0); add(0,1,0,0, 4'b0000,0,1,0);
      add(1,1,1,2, 4'b0100,1,1,1);
      for (int i = 0; i < 3; i++) add(1,1,0,0, 4'b0100,1,1,1);
      add(1,1,0,0, 4'b0000,0,1,0);
      // back-to-back 01 then 11
      add(1,1,1,1, 4'b0010,1,1,1); add(1,1,1,3, 4'b0010,1,0,1);
      add(1,1,0,0, 4'b0010,1,0,1); add(1,1,0,0, 4'b0010,1,0,1);
      for (int i = 0; i < 4; i++) add(1,1,0,0, 4'b1000,1,1,1);
      add(1,1,0,0, 4'b0000,0,1,0);
      // backpressure 0,1,2; code wiggles to 3 while not ready and must be ignored
      add(1,1,1,0, 4'b0001,1,1,1); add(1,1,1,1, 4'b0001,1,0,1);
      add(1,1,1,3, 4'b0001,1,0,1); add(1,1,1,2, 4'b0001,1,0,1);
      add(1,1,1,2, 4'b0010,1,1,1); add(1,1,1,2, 4'b0010,1,0,1);
      add(1,1,0,0, 4'b0010,1,0,1); add(1,1,0,0, 4'b0010,1,0,1);
      for (int i = 0; i < 4; i++) add(1,1,0,0, 4'b0100,1,1,1);
      add(1,1,0,0, 4'b0000,0,1,0);
      // enable gap of 3 cycles inside a hold of 2'b00: 4 visible cycles total
      add(1,1,1,0, 4'b0001,1,1,1); add(1,1,0,0, 4'b0001,1,1,1);
      for (int i = 0; i < 3; i++) add(1,0,0,0, 4'b0000,0,1,1);
      add(1,1,0,0, 4'b0001,1,1,1); add(1,1,0,0, 4'b0001,1,1,1);
      add(1,1,0,0, 4'b0000,0,1,0);
      // transfer while disabled and idle goes to pending, loads once enabled
      add(1,0,1,3, 4'b0000,0,0,1);
      for (int i = 0; i < 4; i++) add(1,1,0,0, 4'b1000,1,1,1);
      add(1,1,0,0, 4'b0000,0,1,0);
      // reset while holding 11 with 01 pending: neither ever shows
      add(1,1,1,3, 4'b1000,1,1,1); add(1,1,1,1, 4'b1000,1,0,1);
      add(0,1,0,0, 4'b0000,0,1,0);
      for (int i = 0; i < 6; i++) add(1,1,0,0, 4'b0000,0,1,0);

      foreach (tbl[i]) begin
         rst_n = tbl[i].rst_n; en = tbl[i].en; in_valid = tbl[i].vld; code = tbl[i].code;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({y, y_valid, in_ready, busy} !== {tbl[i].ey, tbl[i].ev, tbl[i].er, tbl[i].eb}) begin
            errors++;
            $display("FAIL vec%0d: got y=%b yv=%b rdy=%b busy=%b, want y=%b yv=%b rdy=%b busy=%b",
                     i, y, y_valid, in_ready, busy, tbl[i].ey, tbl[i].ev, tbl[i].er, tbl[i].eb);
         end
      end
      in_valid = 1'b0;

      // round trip: priority encoder output for every r streamed one per cycle
      rt_on = 1'b1;
      for (int r = 0; r < 16; r++) begin
         rt_valid = 1'b1;
         rt_code  = prio(r);
         checks++;
         if (rt_ready !== 1'b1) begin
            errors++;
            $display("FAIL rt_ready r=%0d: got %b want 1", r, rt_ready);
         end else begin
            sb.push_back(4'b0001 << prio(r));
         end
         @(posedge clk);
         @(negedge clk);
      end
      rt_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (rt_seen != 16 || sb.size() != 0) begin
         errors++;
         $display("FAIL rt_count: got %0d outputs (%0d outstanding), want 16 (0)",
                  rt_seen, sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
